// File: rtl/csr_exec.sv
// rtl/csr_exec.sv - CSR instruction execution unit (read-modify-write sequencer)
//
// Purpose: accepts one CSR instruction (CSRRW/RS/RC and immediate forms), reads the
// old CSR value, writes the modified value back with a one-cycle strobe, then holds
// the response (old value + illegal flag) until the consumer takes it.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_op/addr/src/zimm/rs1_zero  instruction fields, latched on accept
//   csr_addr/csr_rdata         CSR file read port (rdata combinational on addr)
//   csr_we/csr_wdata           CSR file write strobe and data
//   resp_valid/resp_ready      response handshake
//   resp_rdata/resp_illegal    old CSR value for rd, illegal-instruction flag
module csr_exec #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [11:0]     req_addr,
    input  logic [XLEN-1:0] req_src,
    input  logic [4:0]      req_zimm,
    input  logic            req_rs1_zero,
    output logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            csr_we,
    output logic [XLEN-1:0] csr_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_illegal
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [11:0]       addr_q, addr_d;
    logic [XLEN-1:0]   src_q, src_d;
    logic [4:0]        zimm_q, zimm_d;
    logic              rs1_zero_q, rs1_zero_d;
    logic [XLEN-1:0]   old_q, old_d;

    logic [XLEN-1:0]   operand;
    logic [XLEN-1:0]   new_val;
    logic              write_en;
    logic              addr_ok;
    logic              illegal;

    // Decode of the latched instruction; fields are stable from READ through RESP.
    always_comb begin
        operand = op_q[2] ? {{(XLEN-5){1'b0}}, zimm_q} : src_q;

        // RW forms always write; set/clear forms skip the write when the source is zero.
        if (op_q[1:0] == 2'b01) begin
            write_en = 1'b1;
        end else if (op_q[2]) begin
            write_en = (zimm_q != 5'd0);
        end else begin
            write_en = !rs1_zero_q;
        end

        case (op_q[1:0])
            2'b01:   new_val = operand;
            2'b10:   new_val = old_q | operand;
            2'b11:   new_val = old_q & ~operand;
            default: new_val = '0;
        endcase

        case (addr_q)
            12'h180, 12'h300, 12'h304, 12'h305,
            12'h340, 12'h341, 12'h342, 12'h343, 12'h344: addr_ok = 1'b1;
            default:                                     addr_ok = 1'b0;
        endcase

        // addr[11:10]==2'b11 is the read-only CSR space.
        illegal = (op_q[1:0] == 2'b00) || !addr_ok
                  || (write_en && (addr_q[11:10] == 2'b11));
    end

    // Next-state and latch logic.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        src_d      = src_q;
        zimm_d     = zimm_q;
        rs1_zero_d = rs1_zero_q;
        old_d      = old_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d       = req_op;
                    addr_d     = req_addr;
                    src_d      = req_src;
                    zimm_d     = req_zimm;
                    rs1_zero_d = req_rs1_zero;
                    state_d    = READ;
                end
            end
            READ: begin
                old_d   = csr_rdata;
                state_d = WRITE;
            end
            WRITE: begin
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            src_q      <= '0;
            zimm_q     <= '0;
            rs1_zero_q <= 1'b0;
            old_q      <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            src_q      <= src_d;
            zimm_q     <= zimm_d;
            rs1_zero_q <= rs1_zero_d;
            old_q      <= old_d;
        end
    end

    // Outputs decode straight from the state register, so an asynchronous reset
    // drops csr_we/resp_valid in the same instant.
    always_comb begin
        req_ready    = (state_q == IDLE);
        csr_addr     = addr_q;
        csr_we       = (state_q == WRITE) && !illegal && write_en;
        csr_wdata    = csr_we ? new_val : '0;
        resp_valid   = (state_q == RESP);
        resp_illegal = resp_valid && illegal;
        resp_rdata   = (resp_valid && !illegal) ? old_q : '0;
    end

endmodule
